// File: rtl/dcache_pkg.sv
// dcache_pkg: line geometry, memory FSM states and request fields shared by the cache and its backing memory
package dcache_pkg;
  localparam int LINE_BITS = 256;
  localparam int OFFSET_BITS = 5;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} mem_state_t;
  typedef struct packed {
    logic                 write;
    logic [31:0]          addr;
    logic [LINE_BITS-1:0] data;
  } mem_req_t;
endpackage

// File: rtl/dcache_line_memory_if.sv
// dcache_line_memory_if: cache-to-memory line request/acknowledge bus
interface dcache_line_memory_if #(parameter int LINE_BITS = dcache_pkg::LINE_BITS);
  logic                 req_i;
  logic                 write_i;
  logic [31:0]          addr_i;
  logic [LINE_BITS-1:0] data_i;
  logic                 ack_o;
  logic [LINE_BITS-1:0] data_o;
  logic                 busy_o;
  modport master (output req_i, write_i, addr_i, data_i, input ack_o, data_o, busy_o);
  modport slave (input req_i, write_i, addr_i, data_i, output ack_o, data_o, busy_o);
endinterface

// File: rtl/line_mem_array.sv
// line_mem_array: single-port synchronous line array with registered read data
module line_mem_array #(
  parameter int LINE_BITS = 256,
  parameter int DEPTH = 512
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [LINE_BITS-1:0]     wdata_i,
  output logic [LINE_BITS-1:0]     rdata_o
);
  logic [LINE_BITS-1:0] mem [DEPTH];
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  always_comb rdata_d = (en_i && !we_i) ? mem[idx_i] : rdata_q;
  // contents are deliberately left unreset; only the read register clears
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) mem[idx_i] <= wdata_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else rdata_q <= rdata_d;
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/dcache_line_memory.sv
// dcache_line_memory: fixed-latency line memory answering cache fills and write-backs with a one-cycle ack
module dcache_line_memory #(
  parameter int LINE_BITS = 256,
  parameter int DEPTH = 512,
  parameter int LATENCY = 10
) (
  input logic clk_i,
  input logic rst_i,
  dcache_line_memory_if.slave bus
);
  import dcache_pkg::*;
  localparam int IDX_BITS = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  mem_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d, ack_q, ack_d, busy_q, busy_d;
  logic [IDX_BITS-1:0] idx_q, idx_d, in_idx, mem_idx;
  logic [LINE_BITS-1:0] wdata_q, wdata_d, mem_wdata, rdata;
  logic mem_en, mem_we;
  logic unused_addr;
  assign in_idx = bus.addr_i[OFFSET_BITS +: IDX_BITS];
  assign unused_addr = ^{bus.addr_i[31:OFFSET_BITS+IDX_BITS], bus.addr_i[OFFSET_BITS-1:0]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_d = wr_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    ack_d = 1'b0;
    busy_d = busy_q;
    mem_en = 1'b0;
    mem_we = wr_q;
    mem_idx = idx_q;
    mem_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          wr_d = bus.write_i;
          idx_d = in_idx;
          wdata_d = bus.data_i;
          busy_d = 1'b1;
          cnt_d = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ACK : WAIT;
          ack_d = (LATENCY == 1);
          // single-cycle latency accesses straight from the bus on the capture edge
          mem_en = (LATENCY == 1);
          mem_we = bus.write_i;
          mem_idx = in_idx;
          mem_wdata = bus.data_i;
        end
      end
      WAIT: begin
        mem_en = (cnt_q == '0);
        ack_d = mem_en;
        state_d = mem_en ? ACK : WAIT;
        cnt_d = mem_en ? cnt_q : cnt_q - 1'b1;
      end
      ACK: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
      ack_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      ack_q <= ack_d;
      busy_q <= busy_d;
    end
  end
  line_mem_array #(.LINE_BITS(LINE_BITS), .DEPTH(DEPTH)) u_array (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i(mem_en),
    .we_i(mem_we),
    .idx_i(mem_idx),
    .wdata_i(mem_wdata),
    .rdata_o(rdata)
  );
  assign bus.ack_o = ack_q;
  assign bus.busy_o = busy_q;
  assign bus.data_o = rdata;
endmodule
